// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between instruction fetch (IF) and the
// data-memory stage (DM). Each granted access holds mem_en for MEM_LAT
// cycles. The owner then gets registered read data and a one-cycle ack.
// While idle, DM normally wins. IF wins instead when the previous grant
// went to DM and IF is also waiting, so fetch can never be starved.
//
// Ports
//   clk, rst                       clock (rising edge), async active-low reset
//   if_req/if_addr/if_flush        fetch request, address, cancel
//   if_rdata/if_ack                fetched word, completion pulse
//   dm_req/dm_wr_n/dm_addr/dm_wdata data request (wr_n=0 store, 1 load)
//   dm_rdata/dm_ack                load data, completion pulse
//   mem_en/mem_wr_n/mem_addr/mem_wdata  registered memory controls
//   mem_rdata                      memory read data, valid in last mem_en cycle
//   stall_if/stall_pipe            request outstanding and not yet acked
module mem_port_arbiter #(
  parameter int DSIZE   = 16,
  parameter int ASIZE   = 16,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req,
  input  logic [ASIZE-1:0] if_addr,
  input  logic             if_flush,
  output logic [DSIZE-1:0] if_rdata,
  output logic             if_ack,
  input  logic             dm_req,
  input  logic             dm_wr_n,
  input  logic [ASIZE-1:0] dm_addr,
  input  logic [DSIZE-1:0] dm_wdata,
  output logic [DSIZE-1:0] dm_rdata,
  output logic             dm_ack,
  output logic             mem_en,
  output logic             mem_wr_n,
  output logic [ASIZE-1:0] mem_addr,
  output logic [DSIZE-1:0] mem_wdata,
  input  logic [DSIZE-1:0] mem_rdata,
  output logic             stall_if,
  output logic             stall_pipe
);

  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC} state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t           r_state, w_state;
  logic [3:0]       r_cnt, w_cnt;
  logic             r_last_dm, w_last_dm;
  logic             r_flush_pend, w_flush_pend;
  logic             r_mem_en, w_mem_en;
  logic             r_mem_wr_n, w_mem_wr_n;
  logic [ASIZE-1:0] r_mem_addr, w_mem_addr;
  logic [DSIZE-1:0] r_mem_wdata, w_mem_wdata;
  logic [DSIZE-1:0] r_if_rdata, w_if_rdata;
  logic [DSIZE-1:0] r_dm_rdata, w_dm_rdata;
  logic             r_if_ack, w_if_ack;
  logic             r_dm_ack, w_dm_ack;

  logic w_if_elig, w_dm_elig, w_grant_dm, w_grant_if;

  // A requester whose ack is high this cycle has just been served and is
  // still holding its old request, so it must not be granted again. A
  // fetch arriving together with a flush is stale and is also skipped.
  assign w_if_elig  = if_req & ~r_if_ack & ~if_flush;
  assign w_dm_elig  = dm_req & ~r_dm_ack;
  assign w_grant_dm = w_dm_elig & ~(r_last_dm & w_if_elig);
  assign w_grant_if = w_if_elig & ~w_grant_dm;

  always_comb begin
    // NOTE: every next-state value is defaulted first, so no path through the
    // case statement can leave a signal unassigned and infer a latch.
    w_state      = r_state;
    w_cnt        = r_cnt;
    w_last_dm    = r_last_dm;
    w_flush_pend = r_flush_pend;
    w_mem_en     = r_mem_en;
    w_mem_wr_n   = r_mem_wr_n;
    w_mem_addr   = r_mem_addr;
    w_mem_wdata  = r_mem_wdata;
    w_if_rdata   = r_if_rdata;
    w_dm_rdata   = r_dm_rdata;
    w_if_ack     = 1'b0;
    w_dm_ack     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_grant_dm) begin
          w_state     = DM_ACC;
          w_mem_en    = 1'b1;
          w_mem_wr_n  = dm_wr_n;
          w_mem_addr  = dm_addr;
          w_mem_wdata = dm_wdata;
          w_cnt       = LAT_M1;
          w_last_dm   = 1'b1;
        end else if (w_grant_if) begin
          w_state     = IF_ACC;
          w_mem_en    = 1'b1;
          w_mem_wr_n  = 1'b1;
          w_mem_addr  = if_addr;
          w_mem_wdata = '0;
          w_cnt       = LAT_M1;
          w_last_dm   = 1'b0;
        end
      end

      IF_ACC: begin
        if (r_cnt != 4'd0) begin
          w_cnt        = r_cnt - 4'd1;
          w_flush_pend = r_flush_pend | if_flush;
        end else begin
          // The memory cycle always runs to the end. A flush seen at any
          // point, including this final edge, only suppresses the result.
          if (!(r_flush_pend || if_flush)) begin
            w_if_rdata = mem_rdata;
            w_if_ack   = 1'b1;
          end
          w_flush_pend = 1'b0;
          w_mem_en     = 1'b0;
          w_mem_wr_n   = 1'b1;
          w_state      = IDLE;
        end
      end

      DM_ACC: begin
        if (r_cnt != 4'd0) begin
          w_cnt = r_cnt - 4'd1;
        end else begin
          if (r_mem_wr_n) w_dm_rdata = mem_rdata;
          w_dm_ack   = 1'b1;
          w_mem_en   = 1'b0;
          w_mem_wr_n = 1'b1;
          w_state    = IDLE;
        end
      end

      default: w_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= 4'd0;
      r_last_dm    <= 1'b0;
      r_flush_pend <= 1'b0;
      r_mem_en     <= 1'b0;
      r_mem_wr_n   <= 1'b1;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
      r_if_ack     <= 1'b0;
      r_dm_ack     <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_cnt        <= w_cnt;
      r_last_dm    <= w_last_dm;
      r_flush_pend <= w_flush_pend;
      r_mem_en     <= w_mem_en;
      r_mem_wr_n   <= w_mem_wr_n;
      r_mem_addr   <= w_mem_addr;
      r_mem_wdata  <= w_mem_wdata;
      r_if_rdata   <= w_if_rdata;
      r_dm_rdata   <= w_dm_rdata;
      r_if_ack     <= w_if_ack;
      r_dm_ack     <= w_dm_ack;
    end
  end

  assign if_rdata   = r_if_rdata;
  assign if_ack     = r_if_ack;
  assign dm_rdata   = r_dm_rdata;
  assign dm_ack     = r_dm_ack;
  assign mem_en     = r_mem_en;
  assign mem_wr_n   = r_mem_wr_n;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign stall_if   = if_req & ~r_if_ack;
  assign stall_pipe = dm_req & ~r_dm_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. A fetch agent and a data agent
// issue requests, drop requests that have not been granted, and flush
// fetches. A small memory macro answers the arbiter. The reference model
// tracks each access as a transaction with a completion deadline. It keeps
// its own copy of the memory contents and predicts every output each cycle.
module tb_mem_port_arbiter;
  localparam int DSIZE   = 16;
  localparam int ASIZE   = 16;
  localparam int MEM_LAT = 2;
  localparam int N_CYC   = 4000;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             if_req = 1'b0, if_flush = 1'b0;
  logic [ASIZE-1:0] if_addr = '0;
  logic [DSIZE-1:0] if_rdata;
  logic             if_ack;
  logic             dm_req = 1'b0, dm_wr_n = 1'b1;
  logic [ASIZE-1:0] dm_addr = '0;
  logic [DSIZE-1:0] dm_wdata = '0;
  logic [DSIZE-1:0] dm_rdata;
  logic             dm_ack;
  logic             mem_en, mem_wr_n;
  logic [ASIZE-1:0] mem_addr;
  logic [DSIZE-1:0] mem_wdata, mem_rdata;
  logic             stall_if, stall_pipe;

  mem_port_arbiter #(.DSIZE(DSIZE), .ASIZE(ASIZE), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_ack(if_ack),
    .dm_req(dm_req), .dm_wr_n(dm_wr_n), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack),
    .mem_en(mem_en), .mem_wr_n(mem_wr_n), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_pipe(stall_pipe)
  );

  always #5 clk = ~clk;

  // Memory macro: 16 words selected by the low address bits, combinational
  // read, write on every enabled write-cycle edge.
  logic [DSIZE-1:0] tb_mem [0:15];
  assign mem_rdata = tb_mem[mem_addr[3:0]];
  always @(posedge clk) if (mem_en && !mem_wr_n) tb_mem[mem_addr[3:0]] <= mem_wdata;

  // Reference model. Owner codes: 0 = none, 1 = fetch, 2 = data.
  int               m_owner;
  int               cyc;
  int               done_at;
  bit               m_last_dm, m_flushed, m_wr;
  logic [ASIZE-1:0] m_addr;
  logic [DSIZE-1:0] m_wdata, m_if_rdata, m_dm_rdata;
  bit               m_if_ack, m_dm_ack;
  logic [DSIZE-1:0] m_mem [0:15];

  int n_checks = 0, n_errors = 0;
  int n_if_done = 0, n_dm_done = 0, n_flush_done = 0, n_aborts = 0;
  bit reissue = 1'b0;
  bit want_reset = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner    = 0;
    m_last_dm  = 1'b0;
    m_flushed  = 1'b0;
    m_wr       = 1'b0;
    m_addr     = '0;
    m_wdata    = '0;
    m_if_rdata = '0;
    m_dm_rdata = '0;
    m_if_ack   = 1'b0;
    m_dm_ack   = 1'b0;
    // An abandoned store may have already reached the macro.
    for (int k = 0; k < 16; k++) m_mem[k] = tb_mem[k];
  endtask

  // Advance the model across one rising edge using the inputs now driven.
  task automatic model_step();
    bit n_if_ack, n_dm_ack, f_ok, d_ok;
    n_if_ack = 1'b0;
    n_dm_ack = 1'b0;
    if (m_owner != 0) begin
      if (cyc == done_at) begin
        if (m_owner == 1) begin
          if (!(m_flushed || if_flush)) begin
            m_if_rdata = m_mem[m_addr[3:0]];
            n_if_ack   = 1'b1;
            n_if_done++;
          end else n_flush_done++;
        end else begin
          if (m_wr) m_mem[m_addr[3:0]] = m_wdata;
          else      m_dm_rdata = m_mem[m_addr[3:0]];
          n_dm_ack = 1'b1;
          n_dm_done++;
        end
        m_owner   = 0;
        m_flushed = 1'b0;
      end else if (m_owner == 1 && if_flush) m_flushed = 1'b1;
    end else begin
      f_ok = if_req && !m_if_ack && !if_flush;
      d_ok = dm_req && !m_dm_ack;
      if (d_ok && !(m_last_dm && f_ok)) begin
        m_owner = 2; m_addr = dm_addr; m_wdata = dm_wdata; m_wr = !dm_wr_n;
        m_last_dm = 1'b1; done_at = cyc + MEM_LAT;
      end else if (f_ok) begin
        m_owner = 1; m_addr = if_addr; m_wdata = '0; m_wr = 1'b0;
        m_last_dm = 1'b0; done_at = cyc + MEM_LAT;
      end
    end
    m_if_ack = n_if_ack;
    m_dm_ack = n_dm_ack;
    cyc++;
  endtask

  task automatic compare_outputs();
    check("if_ack",    32'(if_ack),    32'(m_if_ack));
    check("dm_ack",    32'(dm_ack),    32'(m_dm_ack));
    check("mem_en",    32'(mem_en),    32'(m_owner != 0));
    check("mem_wr_n",  32'(mem_wr_n),  32'(!(m_owner == 2 && m_wr)));
    check("mem_addr",  32'(mem_addr),  32'(m_addr));
    check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    check("if_rdata",  32'(if_rdata),  32'(m_if_rdata));
    check("dm_rdata",  32'(dm_rdata),  32'(m_dm_rdata));
  endtask

  task automatic new_dm();
    dm_addr  = 16'($urandom);
    dm_wr_n  = 1'($urandom_range(0, 1));
    dm_wdata = 16'($urandom);
  endtask

  task automatic drive_agents();
    int r;
    if_flush = 1'b0;
    if (reissue && m_owner != 1) begin
      if_addr = 16'($urandom);
      reissue = 1'b0;
    end
    if (if_req && m_if_ack) begin
      if_req  = 1'($urandom_range(0, 1));
      if_addr = 16'($urandom);
    end else if (!if_req) begin
      if ($urandom_range(0, 2) == 0) begin
        if_req  = 1'b1;
        if_addr = 16'($urandom);
      end
    end else if (m_owner == 1) begin
      // The fetch in flight must keep its request; flush it and re-aim later.
      if ($urandom_range(0, 5) == 0) begin
        if_flush = 1'b1;
        reissue  = 1'b1;
      end
    end else begin
      r = int'($urandom_range(0, 15));
      if (r == 0) if_req = 1'b0;
      else if (r < 3) begin
        if_flush = 1'b1;
        if_addr  = 16'($urandom);
      end
    end

    if (dm_req && m_dm_ack) begin
      dm_req = 1'($urandom_range(0, 1));
      new_dm();
    end else if (!dm_req) begin
      if ($urandom_range(0, 2) == 0) begin
        dm_req = 1'b1;
        new_dm();
      end
    end else if (m_owner != 2 && $urandom_range(0, 15) == 0) dm_req = 1'b0;
  endtask

  // Reset while an access may be in flight. Called just after a falling edge.
  task automatic abort_reset();
    n_aborts++;
    rst = 1'b0;
    #1;
    check("rst_mem_en",   32'(mem_en),   32'd0);
    check("rst_mem_wr_n", 32'(mem_wr_n), 32'd1);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_if_ack",   32'(if_ack),   32'd0);
    check("rst_dm_ack",   32'(dm_ack),   32'd0);
    check("rst_if_rdata", 32'(if_rdata), 32'd0);
    check("rst_dm_rdata", 32'(dm_rdata), 32'd0);
    model_reset();
    reissue  = 1'b0;
    if_flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
    rst = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 16; k++) begin
      tb_mem[k] = 16'($urandom);
    end
    cyc = 0;
    #1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_outputs();
    check("rst_stall_if",   32'(stall_if),   32'd0);
    check("rst_stall_pipe", 32'(stall_pipe), 32'd0);
    rst = 1'b1;
    model_step();

    for (int i = 0; i < N_CYC; i++) begin
      @(negedge clk);
      compare_outputs();
      if (i == N_CYC / 2) want_reset = 1'b1;
      if ((want_reset && m_owner == 2) ||
          (m_owner != 0 && $urandom_range(0, 299) == 0)) begin
        if (m_owner == 2) want_reset = 1'b0;
        abort_reset();
      end
      drive_agents();
      #1;
      check("stall_if",   32'(stall_if),   32'(if_req & ~m_if_ack));
      check("stall_pipe", 32'(stall_pipe), 32'(dm_req & ~m_dm_ack));
      model_step();
    end

    // Guard against a run whose traffic never exercised the main paths.
    check("if_acks_seen",     32'(n_if_done > 20),    32'd1);
    check("dm_acks_seen",     32'(n_dm_done > 20),    32'd1);
    check("flushed_seen",     32'(n_flush_done > 2),  32'd1);
    check("dm_abort_done",    32'(want_reset),        32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
